// File: rtl/triple.sv
`default_nettype none
// ============================================================================
//  Module      : triple
//  Description : Ready/valid multiplier-by-three. Accepts an unsigned
//                WIDTH-bit operand and returns the exact product 3*x on a
//                WIDTH+2-bit result through a single output register.
//                Back-pressure is honoured. The only combinational path
//                runs from result_ready to num_ready.
//  Ports       : clk           - clock, rising edge
//                rst_n         - synchronous active-low reset
//                num_valid     - operand present on num_value
//                num_value     - unsigned operand, WIDTH bits
//                num_ready     - stage can take an operand this cycle
//                result_valid  - result holds a valid product
//                result        - 3*num_value, WIDTH+2 bits
//                result_ready  - downstream accepts result this cycle
//                result_parity - XOR-reduce of result (TRIPLE_PARITY_EN only)
//  Options     : `define TRIPLE_PARITY_EN adds the registered result_parity
//                output. Without it the port and its logic are absent.
//  Revision    : 1.0 - initial release
// ============================================================================
module triple #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               num_valid,
    input  logic [WIDTH-1:0]   num_value,
    output logic               num_ready,
    output logic               result_valid,
    output logic [WIDTH+1:0]   result,
    input  logic               result_ready
`ifdef TRIPLE_PARITY_EN
    ,
    output logic               result_parity
`endif
);

    logic               w_accept;
    logic [WIDTH+1:0]   w_product;
    logic               r_valid;
    logic [WIDTH+1:0]   r_result;

    // A slot frees up either when it is empty or when its content leaves now.
    assign num_ready = !r_valid || result_ready;
    assign w_accept  = num_valid && num_ready;

    // (x << 1) + x; 3*(2^WIDTH-1) always fits in WIDTH+2 bits.
    assign w_product = {1'b0, num_value, 1'b0} + {2'b00, num_value};

    // result only loads on acceptance, so num_value is never sampled
    // while num_valid is low. On output-only handshakes result keeps its
    // last value and just result_valid drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_result <= w_product;
        end else if (r_valid && result_ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign result_valid = r_valid;
    assign result       = r_result;

`ifdef TRIPLE_PARITY_EN
    logic r_parity;

    // Computed from the incoming product so it lands together with result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^w_product;
        end
    end

    assign result_parity = r_parity;
`endif

endmodule
`default_nettype wire

// File: tb/tb_triple.sv
`default_nettype none
// ============================================================================
//  Module      : tb_triple
//  Description : Directed self-checking bench for triple (WIDTH=4).
//                Define TRIPLE_PARITY_EN for both files to cover parity.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_triple;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             num_valid;
    logic [WIDTH-1:0] num_value;
    logic             num_ready;
    logic             result_valid;
    logic [WIDTH+1:0] result;
    logic             result_ready;
`ifdef TRIPLE_PARITY_EN
    logic             result_parity;
`endif

    int n_checks;
    int n_fail;

    triple #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .num_valid    (num_valid),
        .num_value    (num_value),
        .num_ready    (num_ready),
        .result_valid (result_valid),
        .result       (result),
        .result_ready (result_ready)
`ifdef TRIPLE_PARITY_EN
        ,
        .result_parity(result_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; num_valid = 1'b1; num_value = 4'd7; result_ready = 1'b1;
        tick();
        tick();
        n_checks++;
        if (result_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", result_valid);
        end
        n_checks++;
        if (result !== 6'd0) begin
            n_fail++; $display("FAIL reset_result: got %0d expected 0", result);
        end
`ifdef TRIPLE_PARITY_EN
        n_checks++;
        if (result_parity !== 1'b0) begin
            n_fail++; $display("FAIL reset_parity: got %b expected 0", result_parity);
        end
`endif
        rst_n = 1'b1; num_valid = 1'b0;
        #1;
        n_checks++;
        if (num_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 1", num_ready);
        end
        tick();
        n_checks++;
        if (result_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_valid: got %b expected 0", result_valid);
        end
    endtask

    task automatic test_sweep();
        logic [WIDTH-1:0] ops [6];
        logic [WIDTH+1:0] exp [6];
        ops = '{4'd0, 4'd1, 4'd3, 4'd5, 4'd10, 4'd15};
        exp = '{6'd0, 6'd3, 6'd9, 6'd15, 6'd30, 6'd45};
        result_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            num_valid = 1'b1; num_value = ops[i];
            #1;
            n_checks++;
            if (num_ready !== 1'b1) begin
                n_fail++; $display("FAIL sweep_ready[%0d]: got %b expected 1", i, num_ready);
            end
            tick();
            n_checks++;
            if (result_valid !== 1'b1 || result !== exp[i]) begin
                n_fail++;
                $display("FAIL sweep[%0d]: got valid=%b result=%0d expected valid=1 result=%0d",
                         i, result_valid, result, exp[i]);
            end
        end
        num_valid = 1'b0;
        tick();
        n_checks++;
        if (result_valid !== 1'b0 || result !== 6'd45) begin
            n_fail++;
            $display("FAIL sweep_drain: got valid=%b result=%0d expected valid=0 result=45",
                     result_valid, result);
        end
    endtask

    task automatic test_back_pressure();
        result_ready = 1'b1; num_valid = 1'b1; num_value = 4'd5;
        tick();
        result_ready = 1'b0; num_value = 4'd10;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (num_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, num_ready);
            end
            tick();
            n_checks++;
            if (result_valid !== 1'b1 || result !== 6'd15) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%b result=%0d expected valid=1 result=15",
                         i, result_valid, result);
            end
        end
        result_ready = 1'b1;
        #1;
        n_checks++;
        if (num_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release_ready: got %b expected 1", num_ready);
        end
        tick();
        n_checks++;
        if (result_valid !== 1'b1 || result !== 6'd30) begin
            n_fail++;
            $display("FAIL bp_release: got valid=%b result=%0d expected valid=1 result=30",
                     result_valid, result);
        end
        num_valid = 1'b0;
        tick();
        n_checks++;
        if (result_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_drain: got %b expected 0", result_valid);
        end
    endtask

    task automatic test_back_to_back();
        result_ready = 1'b1; num_valid = 1'b1; num_value = 4'd3;
        tick();
        n_checks++;
        if (result_valid !== 1'b1 || result !== 6'd9) begin
            n_fail++;
            $display("FAIL b2b_first: got valid=%b result=%0d expected valid=1 result=9",
                     result_valid, result);
        end
        num_value = 4'd15;
        tick();
        n_checks++;
        if (result_valid !== 1'b1 || result !== 6'd45) begin
            n_fail++;
            $display("FAIL b2b_second: got valid=%b result=%0d expected valid=1 result=45",
                     result_valid, result);
        end
        num_valid = 1'b0;
        tick();
    endtask

    task automatic test_midstream_reset();
        result_ready = 1'b1; num_valid = 1'b1; num_value = 4'd10;
        tick();
        n_checks++;
        if (result !== 6'd30) begin
            n_fail++; $display("FAIL mr_setup: got %0d expected 30", result);
        end
        rst_n = 1'b0; num_value = 4'd5;
        tick();
        n_checks++;
        if (result_valid !== 1'b0 || result !== 6'd0) begin
            n_fail++;
            $display("FAIL mr_reset: got valid=%b result=%0d expected valid=0 result=0",
                     result_valid, result);
        end
        rst_n = 1'b1; num_valid = 1'b0;
        tick();
        n_checks++;
        if (result_valid !== 1'b0 || result !== 6'd0) begin
            n_fail++;
            $display("FAIL mr_after: got valid=%b result=%0d expected valid=0 result=0",
                     result_valid, result);
        end
    endtask

    task automatic test_ignore_idle_input();
        result_ready = 1'b1; num_valid = 1'b1; num_value = 4'd4;
        tick();
        num_valid = 1'b0; num_value = 'x;
        tick();
        tick();
        n_checks++;
        if (result_valid !== 1'b0 || result !== 6'd12) begin
            n_fail++;
            $display("FAIL idle_input: got valid=%b result=%0d expected valid=0 result=12",
                     result_valid, result);
        end
        num_value = '0;
    endtask

`ifdef TRIPLE_PARITY_EN
    task automatic test_parity();
        logic [WIDTH-1:0] ops [8];
        logic [WIDTH+1:0] exp [8];
        logic             par [8];
        ops = '{4'd15, 4'd1, 4'd3, 4'd5, 4'd10, 4'd2, 4'd4, 4'd7};
        exp = '{6'd45, 6'd3, 6'd9, 6'd15, 6'd30, 6'd6, 6'd12, 6'd21};
        par = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        result_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            num_valid = 1'b1; num_value = ops[i];
            tick();
            n_checks++;
            if (result !== exp[i] || result_parity !== par[i]) begin
                n_fail++;
                $display("FAIL parity[%0d]: got result=%0d parity=%b expected result=%0d parity=%b",
                         i, result, result_parity, exp[i], par[i]);
            end
        end
        // Held under stall while a new operand is offered.
        result_ready = 1'b0; num_value = 4'd1;
        tick();
        tick();
        n_checks++;
        if (result !== 6'd21 || result_parity !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_stall: got result=%0d parity=%b expected result=21 parity=1",
                     result, result_parity);
        end
        result_ready = 1'b1; num_valid = 1'b0;
        tick();
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; num_valid = 1'b0; num_value = '0; result_ready = 1'b0;
        #2;
        test_reset();
        test_sweep();
        test_back_pressure();
        test_back_to_back();
        test_midstream_reset();
        test_ignore_idle_input();
`ifdef TRIPLE_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
